// File: rtl/jt12_mmr_wr_if.sv
// rtl/jt12_mmr_wr_if.sv - CPU bus and register-update bundle for jt12_mmr_wr
interface jt12_mmr_wr_if;
  logic        clk_en;
  logic [7:0]  cpu_din;
  logic [1:0]  addr;
  logic        cs_n;
  logic        wr_n;
  logic        busy;
  logic [7:0]  din;
  logic [2:0]  ch;
  logic [1:0]  op;
  logic        up_keyon, up_alg, up_fnumlo, up_pms, up_dt1, up_tl;
  logic        up_ks_ar, up_amen_dr, up_sr, up_sl_rr, up_ssgeg;
  logic [5:0]  latch_fnum;
  logic        effect;
  logic        csm;
  logic [10:0] fnum_ch3op1, fnum_ch3op2, fnum_ch3op3;
  logic [2:0]  block_ch3op1, block_ch3op2, block_ch3op3;

  modport master (
    output clk_en, cpu_din, addr, cs_n, wr_n,
    input  busy, din, ch, op,
    input  up_keyon, up_alg, up_fnumlo, up_pms, up_dt1, up_tl,
    input  up_ks_ar, up_amen_dr, up_sr, up_sl_rr, up_ssgeg,
    input  latch_fnum, effect, csm,
    input  fnum_ch3op1, fnum_ch3op2, fnum_ch3op3,
    input  block_ch3op1, block_ch3op2, block_ch3op3
  );

  modport slave (
    input  clk_en, cpu_din, addr, cs_n, wr_n,
    output busy, din, ch, op,
    output up_keyon, up_alg, up_fnumlo, up_pms, up_dt1, up_tl,
    output up_ks_ar, up_amen_dr, up_sr, up_sl_rr, up_ssgeg,
    output latch_fnum, effect, csm,
    output fnum_ch3op1, fnum_ch3op2, fnum_ch3op3,
    output block_ch3op1, block_ch3op2, block_ch3op3
  );
endinterface

// File: rtl/jt12_mmr_wr.sv
// rtl/jt12_mmr_wr.sv - YM2612 CPU write decoder; holds one update strobe for a full slot sweep
module jt12_mmr_wr #(
  parameter int num_ch = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  jt12_mmr_wr_if.slave bus
);
  localparam int            SWEEP = 4 * num_ch;
  localparam int            CW    = $clog2(SWEEP);
  localparam logic [CW-1:0] LAST  = CW'(SWEEP - 1);

  logic          r_wr_prev;
  logic [7:0]    r_sel;
  logic          r_part;
  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [10:0]   r_up;
  logic [7:0]    r_din;
  logic [2:0]    r_ch;
  logic [1:0]    r_op;
  logic [5:0]    r_latch_fnum;
  logic [5:0]    r_ch3_latch;
  logic          r_effect;
  logic          r_csm;
  logic [10:0]   r_fnum  [3];
  logic [2:0]    r_block [3];

  logic        w_bus_n;
  logic        w_event;
  logic        w_data_ok;
  logic        w_bad_ch;
  logic [10:0] w_up;
  logic        w_ld_fnum;
  logic        w_ld_ch3l;
  logic [2:0]  w_ld_op;
  logic        w_ld_mode;

  assign w_bus_n   = bus.cs_n | bus.wr_n;
  assign w_event   = r_wr_prev & ~w_bus_n;
  // busy is the registered value, so a write landing on the expiry clk is still dropped
  assign w_data_ok = w_event & bus.addr[0] & ~r_busy & ~(r_part & (num_ch == 3));
  assign w_bad_ch  = (r_sel[1:0] == 2'b11);

  // strobe vector bit order: keyon, alg, fnumlo, pms, dt1, tl, ks_ar, amen_dr, sr, sl_rr, ssgeg
  always_comb begin
    w_up      = '0;
    w_ld_fnum = 1'b0;
    w_ld_ch3l = 1'b0;
    w_ld_op   = '0;
    w_ld_mode = 1'b0;
    if (w_data_ok) begin
      if (r_sel == 8'h27) begin
        w_ld_mode = ~r_part;
      end else if (r_sel == 8'h28) begin
        w_up[0] = ~r_part;
      end else if (!w_bad_ch) begin
        if (r_sel[7:4] >= 4'h3 && r_sel[7:4] <= 4'h9) begin
          w_up = 11'd1 << (r_sel[7:4] + 4'd1);
        end else begin
          case (r_sel[7:2])
            6'b101000: w_up[2]   = 1'b1;
            6'b101001: w_ld_fnum = 1'b1;
            6'b101010: w_ld_op   = r_part ? 3'b000 :
                                   {r_sel[1:0] == 2'b00, r_sel[1:0] == 2'b10, r_sel[1:0] == 2'b01};
            6'b101011: w_ld_ch3l = ~r_part;
            6'b101100: w_up[1]   = 1'b1;
            6'b101101: w_up[3]   = 1'b1;
            default:   ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_prev    <= 1'b1;
      r_sel        <= '0;
      r_part       <= 1'b0;
      r_busy       <= 1'b0;
      r_cnt        <= '0;
      r_up         <= '0;
      r_din        <= '0;
      r_ch         <= '0;
      r_op         <= '0;
      r_latch_fnum <= '0;
      r_ch3_latch  <= '0;
      r_effect     <= 1'b0;
      r_csm        <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        r_fnum[k]  <= '0;
        r_block[k] <= '0;
      end
    end else begin
      r_wr_prev <= w_bus_n;
      if (w_event && !bus.addr[0]) begin
        r_sel  <= bus.cpu_din;
        r_part <= bus.addr[1];
      end
      if (w_ld_fnum) r_latch_fnum <= bus.cpu_din[5:0];
      if (w_ld_ch3l) r_ch3_latch  <= bus.cpu_din[5:0];
      for (int k = 0; k < 3; k++) begin
        if (w_ld_op[k]) begin
          r_fnum[k]  <= {r_ch3_latch[2:0], bus.cpu_din};
          r_block[k] <= r_ch3_latch[5:3];
        end
      end
      if (w_ld_mode) begin
        r_effect <= |bus.cpu_din[7:6];
        r_csm    <= (bus.cpu_din[7:6] == 2'b10);
      end
      if (|w_up) begin
        r_up   <= w_up;
        r_busy <= 1'b1;
        r_cnt  <= '0;
        r_din  <= bus.cpu_din;
        r_ch   <= {r_part, r_sel[1:0]};
        r_op   <= r_sel[3:2];
      end else if (r_busy && bus.clk_en) begin
        if (r_cnt == LAST) begin
          r_busy <= 1'b0;
          r_up   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.busy         = r_busy;
  assign bus.din          = r_din;
  assign bus.ch           = r_ch;
  assign bus.op           = r_op;
  assign bus.up_keyon     = r_up[0];
  assign bus.up_alg       = r_up[1];
  assign bus.up_fnumlo    = r_up[2];
  assign bus.up_pms       = r_up[3];
  assign bus.up_dt1       = r_up[4];
  assign bus.up_tl        = r_up[5];
  assign bus.up_ks_ar     = r_up[6];
  assign bus.up_amen_dr   = r_up[7];
  assign bus.up_sr        = r_up[8];
  assign bus.up_sl_rr     = r_up[9];
  assign bus.up_ssgeg     = r_up[10];
  assign bus.latch_fnum   = r_latch_fnum;
  assign bus.effect       = r_effect;
  assign bus.csm          = r_csm;
  assign bus.fnum_ch3op1  = r_fnum[0];
  assign bus.fnum_ch3op2  = r_fnum[1];
  assign bus.fnum_ch3op3  = r_fnum[2];
  assign bus.block_ch3op1 = r_block[0];
  assign bus.block_ch3op2 = r_block[1];
  assign bus.block_ch3op3 = r_block[2];
endmodule
